// File: rtl/multiplier_arbiter.sv
// Round-robin front end that time-shares one masked multiplier among N_REQ requesters,
// owns the reduction polynomial register and aborts stuck operations with a watchdog.
module multiplier_arbiter #(
    parameter int d       = 2,
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cfg_we,
    input  logic [7:0]                    cfg_P,
    output logic                          busy,
    input  logic [N_REQ-1:0]              req_valid,
    input  logic [N_REQ-1:0][(d+1)*8-1:0] req_p1,
    input  logic [N_REQ-1:0][(d+1)*8-1:0] req_p2,
    output logic [N_REQ-1:0]              req_gnt,
    output logic [N_REQ-1:0]              rsp_valid,
    output logic [(d+1)*8-1:0]            rsp_out,
    output logic                          rsp_err,
    output logic                          timeout_err,
    input  logic                          err_clr,
    output logic [(d+1)*8-1:0]            m_p1,
    output logic [(d+1)*8-1:0]            m_p2,
    output logic [7:0]                    m_P,
    output logic                          m_drdy_i,
    input  logic                          m_drdy_o,
    input  logic [(d+1)*8-1:0]            m_out,
    output logic                          m_rst
);
    localparam int SW = (d + 1) * 8;
    localparam int IW = $clog2(N_REQ);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} arb_state_t;

    arb_state_t       state_reg;
    logic [IW-1:0]    ptr_reg;
    logic [IW-1:0]    owner_reg;
    logic [CW-1:0]    cnt_reg;
    logic [7:0]       p_reg;
    logic [SW-1:0]    m_p1_reg;
    logic [SW-1:0]    m_p2_reg;
    logic [SW-1:0]    rsp_out_reg;
    logic             rsp_err_reg;
    logic             timeout_err_reg;
    logic             m_drdy_i_reg;
    logic [N_REQ-1:0] rsp_valid_reg;
    logic             m_rst_n_reg;

    logic             gnt_found;
    logic [IW-1:0]    gnt_idx;
    int               j;

    // First pending requester at or after ptr, wrapping around.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        j         = 0;
        req_gnt   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            j = (int'(ptr_reg) + k) % N_REQ;
            if (!gnt_found && req_valid[j]) begin
                gnt_found = 1'b1;
                gnt_idx   = IW'(j);
            end
        end
        if (state_reg == IDLE && gnt_found) begin
            req_gnt[gnt_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg       <= IDLE;
            ptr_reg         <= '0;
            owner_reg       <= '0;
            cnt_reg         <= '0;
            p_reg           <= '0;
            m_p1_reg        <= '0;
            m_p2_reg        <= '0;
            rsp_out_reg     <= '0;
            rsp_err_reg     <= 1'b0;
            timeout_err_reg <= 1'b0;
            m_drdy_i_reg    <= 1'b0;
            rsp_valid_reg   <= '0;
            m_rst_n_reg     <= 1'b1;
        end else begin
            m_drdy_i_reg  <= 1'b0;
            rsp_valid_reg <= '0;
            m_rst_n_reg   <= 1'b1;
            if (err_clr) begin
                timeout_err_reg <= 1'b0;
            end
            case (state_reg)
                IDLE: begin
                    if (cfg_we) begin
                        p_reg <= cfg_P;
                    end
                    if (gnt_found) begin
                        m_p1_reg     <= req_p1[gnt_idx];
                        m_p2_reg     <= req_p2[gnt_idx];
                        owner_reg    <= gnt_idx;
                        ptr_reg      <= (gnt_idx == IW'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
                        m_drdy_i_reg <= 1'b1;
                        state_reg    <= ISSUE;
                    end
                end
                ISSUE: begin
                    cnt_reg   <= '0;
                    state_reg <= WAIT;
                end
                WAIT: begin
                    // A product arriving on the last allowed cycle still counts as success.
                    if (m_drdy_o) begin
                        rsp_out_reg   <= m_out;
                        rsp_err_reg   <= 1'b0;
                        rsp_valid_reg <= N_REQ'(1) << owner_reg;
                        state_reg     <= RESP;
                    end else if (cnt_reg == CW'(TIMEOUT)) begin
                        rsp_out_reg     <= '0;
                        rsp_err_reg     <= 1'b1;
                        timeout_err_reg <= 1'b1;
                        m_rst_n_reg     <= 1'b0;
                        rsp_valid_reg   <= N_REQ'(1) << owner_reg;
                        state_reg       <= RESP;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                RESP: begin
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign busy        = (state_reg != IDLE);
    assign rsp_valid   = rsp_valid_reg;
    assign rsp_out     = rsp_out_reg;
    assign rsp_err     = rsp_err_reg;
    assign timeout_err = timeout_err_reg;
    assign m_p1        = m_p1_reg;
    assign m_p2        = m_p2_reg;
    assign m_P         = p_reg;
    assign m_drdy_i    = m_drdy_i_reg;
    // Multiplier is held in reset with the arbiter and pulsed after an abort.
    assign m_rst       = rst & m_rst_n_reg;

endmodule

// File: tb/tb_multiplier_arbiter.sv
// Directed bench for multiplier_arbiter: a GF(2^8) multiplier model with programmable
// latency, a table of grant/latency/config vectors, and hand sequences for corner cases.
module tb_multiplier_arbiter;
    localparam int D       = 2;
    localparam int NREQ    = 4;
    localparam int TMO     = 10;
    localparam int SW      = (D + 1) * 8;

    logic                      clk = 1'b0;
    logic                      rst = 1'b0;
    logic                      cfg_we = 1'b0;
    logic [7:0]                cfg_P = 8'h00;
    logic                      busy;
    logic [NREQ-1:0]           req_valid = '0;
    logic [NREQ-1:0][SW-1:0]   req_p1;
    logic [NREQ-1:0][SW-1:0]   req_p2;
    logic [NREQ-1:0]           req_gnt;
    logic [NREQ-1:0]           rsp_valid;
    logic [SW-1:0]             rsp_out;
    logic                      rsp_err;
    logic                      timeout_err;
    logic                      err_clr = 1'b0;
    logic [SW-1:0]             m_p1;
    logic [SW-1:0]             m_p2;
    logic [7:0]                m_P;
    logic                      m_drdy_i;
    logic                      m_drdy_o = 1'b0;
    logic [SW-1:0]             m_out = '0;
    logic                      m_rst;

    int n_cmp = 0;
    int n_err = 0;
    int model_lat = 0;
    int rem = 0;
    logic [7:0] cur_P = 8'h00;
    bit sticky = 1'b0;
    logic [7:0] op_a [NREQ];
    logic [7:0] op_b [NREQ];

    multiplier_arbiter #(.d(D), .N_REQ(NREQ), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_P(cfg_P), .busy(busy),
        .req_valid(req_valid), .req_p1(req_p1), .req_p2(req_p2), .req_gnt(req_gnt),
        .rsp_valid(rsp_valid), .rsp_out(rsp_out), .rsp_err(rsp_err),
        .timeout_err(timeout_err), .err_clr(err_clr), .m_p1(m_p1), .m_p2(m_p2),
        .m_P(m_P), .m_drdy_i(m_drdy_i), .m_drdy_o(m_drdy_o), .m_out(m_out), .m_rst(m_rst)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b, input logic [7:0] poly);
        logic [7:0] r = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) r = r ^ x;
            x = x[7] ? ((x << 1) ^ poly) : (x << 1);
        end
        return r;
    endfunction

    function automatic logic [SW-1:0] enc(input logic [7:0] v, input logic [7:0] m1, input logic [7:0] m2);
        return {m2, m1, v ^ m1 ^ m2};
    endfunction

    function automatic logic [7:0] dec(input logic [SW-1:0] s);
        return s[23:16] ^ s[15:8] ^ s[7:0];
    endfunction

    // Multiplier model: product appears L cycles after the start strobe; never when L = 0.
    always @(posedge clk) begin
        m_drdy_o <= 1'b0;
        if (!m_rst) begin
            rem <= 0;
        end else if (m_drdy_i && model_lat != 0) begin
            if (model_lat == 1) begin
                m_drdy_o <= 1'b1;
                m_out    <= enc(gf_mul(dec(m_p1), dec(m_p2), m_P), 8'h5A, 8'hC3);
            end else begin
                rem <= model_lat - 1;
            end
        end else if (rem != 0) begin
            rem <= rem - 1;
            if (rem == 1) begin
                m_drdy_o <= 1'b1;
                m_out    <= enc(gf_mul(dec(m_p1), dec(m_p2), m_P), 8'h5A, 8'hC3);
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic do_op(input logic [3:0] valid, input int lat, input int owner,
                         input bit exp_to, input bit cfg_en, input logic [7:0] cfg_val);
        int cyc;
        logic [SW-1:0] exp_out;
        @(posedge clk); #1;
        req_valid = valid;
        model_lat = lat;
        cfg_we    = cfg_en;
        cfg_P     = cfg_val;
        if (cfg_en) cur_P = cfg_val;
        @(negedge clk);
        check("req_gnt", req_gnt, 64'(1) << owner);
        check("busy_idle", busy, 0);
        @(posedge clk); #1;
        req_valid = '0;
        cfg_we    = 1'b0;
        @(negedge clk);
        check("m_drdy_i", m_drdy_i, 1);
        check("m_P_issue", m_P, cur_P);
        check("m_p1", m_p1, req_p1[owner]);
        check("busy_issue", busy, 1);
        cyc = 1;
        while (rsp_valid == '0 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        check("rsp_latency", cyc, exp_to ? TMO + 3 : lat + 2);
        if (exp_to) sticky = 1'b1;
        exp_out = exp_to ? '0 : enc(gf_mul(op_a[owner], op_b[owner], cur_P), 8'h5A, 8'hC3);
        check("rsp_valid", rsp_valid, 64'(1) << owner);
        check("rsp_out", rsp_out, exp_out);
        check("rsp_err", rsp_err, exp_to);
        check("timeout_err", timeout_err, sticky);
        check("m_rst_resp", m_rst, !exp_to);
        check("m_P_resp", m_P, cur_P);
        $display("op: valid=%b owner=%0d lat=%0d rsp_valid=%b rsp_out=%h err=%0d", valid, owner, lat, rsp_valid, rsp_out, rsp_err);
        if (exp_to) begin
            @(negedge clk);
            check("m_rst_after", m_rst, 1);
            check("rsp_valid_pulse", rsp_valid, 0);
        end
    endtask

    typedef struct {
        logic [3:0] valid;
        int         lat;
        int         owner;
        bit         to;
        bit         cfg_en;
        logic [7:0] cfg;
    } vec_t;

    vec_t vecs [11];

    initial begin
        int bad;
        for (int i = 0; i < NREQ; i++) begin
            op_a[i]   = 8'h3C + 8'(i * 8'h21);
            op_b[i]   = 8'hA5 ^ 8'(i * 8'h17);
            req_p1[i] = enc(op_a[i], 8'h10 + 8'(i), 8'h99 ^ 8'(i));
            req_p2[i] = enc(op_b[i], 8'h71 ^ 8'(i), 8'h2E + 8'(i));
        end
        vecs[0]  = '{4'b0001,  5, 0, 1'b0, 1'b1, 8'h1B};
        vecs[1]  = '{4'b1111,  4, 1, 1'b0, 1'b0, 8'h00};
        vecs[2]  = '{4'b1111,  2, 2, 1'b0, 1'b0, 8'h00};
        vecs[3]  = '{4'b1111,  1, 3, 1'b0, 1'b0, 8'h00};
        vecs[4]  = '{4'b1111,  6, 0, 1'b0, 1'b0, 8'h00};
        vecs[5]  = '{4'b0101,  3, 2, 1'b0, 1'b0, 8'h00};
        vecs[6]  = '{4'b1001,  2, 3, 1'b0, 1'b0, 8'h00};
        vecs[7]  = '{4'b0110,  1, 1, 1'b0, 1'b1, 8'h63};
        vecs[8]  = '{4'b1011, 11, 3, 1'b0, 1'b0, 8'h00};
        vecs[9]  = '{4'b0011,  0, 0, 1'b1, 1'b0, 8'h00};
        vecs[10] = '{4'b0100, 12, 2, 1'b1, 1'b0, 8'h00};

        // Reset state
        #12;
        check("rst_busy", busy, 0);
        check("rst_m_rst", m_rst, 0);
        check("rst_m_drdy_i", m_drdy_i, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_out", rsp_out, 0);
        check("rst_m_P", m_P, 0);
        check("rst_m_p1", m_p1, 0);
        check("rst_timeout_err", timeout_err, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("m_rst_release", m_rst, 1);

        foreach (vecs[i]) begin
            do_op(vecs[i].valid, vecs[i].lat, vecs[i].owner, vecs[i].to, vecs[i].cfg_en, vecs[i].cfg);
        end

        // err_clr clears the sticky flag
        @(posedge clk); #1;
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        sticky  = 1'b0;
        @(negedge clk);
        check("err_clr", timeout_err, 0);

        // cfg_we during WAIT must not change P
        fork
            do_op(4'b0001, 5, 0, 1'b0, 1'b0, 8'h00);
            begin
                repeat (4) @(posedge clk);
                #1;
                cfg_we = 1'b1;
                cfg_P  = 8'h4D;
                @(posedge clk); #1;
                cfg_we = 1'b0;
            end
        join

        // Reset in the middle of WAIT
        @(posedge clk); #1;
        req_valid = 4'b0100;
        model_lat = 0;
        @(posedge clk); #1;
        req_valid = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        cur_P = 8'h00;
        #1;
        check("mid_busy", busy, 0);
        check("mid_m_rst", m_rst, 0);
        check("mid_rsp_valid", rsp_valid, 0);
        check("mid_rsp_out", rsp_out, 0);
        check("mid_m_p1", m_p1, 0);
        check("mid_m_P", m_P, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        bad = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (rsp_valid != '0) bad++;
        end
        check("no_rsp_after_reset", bad, 0);
        do_op(4'b1111, 3, 0, 1'b0, 1'b1, 8'h1B);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/multiplier_arbiter.md
# multiplier_arbiter

Round-robin scheduler that shares one serial-mode masked multiplier among `N_REQ` requesters. It captures one requester's operand pair and issues it to the multiplier with a single-cycle `drdy_i` strobe. It then waits for `drdy_o` and routes the product back to the owning requester. It also holds the reduction polynomial `P` register and guards the multiplier with a watchdog. It sits between the CLM round logic and the multiplier instance.

## Interface
Clocking: one clock; reset is asynchronous and active-low.

Parameters
- `d`, default 2: masking order, forwarded to `state_t` sizing from `types`.
- `N_REQ`, default 4: number of requesters, 2..8.
- `TIMEOUT`, default 255: maximum number of WAIT cycles before abort, 1..65535.

Ports
- `clk`, in, 1: clock.
- `rst`, in, 1: asynchronous active-low reset.
- `cfg_we`, in, 1: load `cfg_P` into the `P` register. Honoured only in IDLE.
- `cfg_P`, in, `base_poly_t`: new polynomial.
- `busy`, out, 1: state is not IDLE.
- `req_valid`, in, `N_REQ`: per-requester operand valid. Held until granted.
- `req_p1`, `req_p2`, in, `N_REQ` × `state_t`: per-requester operands.
- `req_gnt`, out, `N_REQ`: one-hot, combinational. Operands are taken in this cycle.
- `rsp_valid`, out, `N_REQ`: one-hot single-cycle response pulse.
- `rsp_out`, out, `state_t`: product. Held until the next response.
- `rsp_err`, out, 1: qualifies `rsp_valid`; the operation was aborted by the watchdog.
- `timeout_err`, out, 1: sticky watchdog flag.
- `err_clr`, in, 1: clears `timeout_err`.
- `m_p1`, `m_p2`, out, `state_t`: multiplier operands.
- `m_P`, out, `base_poly_t`: multiplier polynomial.
- `m_drdy_i`, out, 1: multiplier start strobe.
- `m_drdy_o`, in, 1: multiplier done.
- `m_out`, in, `state_t`: multiplier product.
- `m_rst`, out, 1: active-low multiplier reset.

## Operation
- **States**: IDLE → ISSUE → WAIT → RESP → IDLE.
- **IDLE**
  - If any `req_valid` is set, grant the first set bit searching from `ptr`, wrapping modulo `N_REQ`.
  - `req_gnt[i]` = 1 in the same cycle.
  - Register `req_p1[i]`/`req_p2[i]` into `m_p1`/`m_p2` and record owner `i`.
  - Update `ptr` to (i+1) mod `N_REQ`, then go to ISSUE.
  - With no request, stay in IDLE. `req_gnt` = 0.
- **cfg_we**
  - In IDLE, `P` ← `cfg_P` at the clock edge.
  - A grant in the same cycle issues with the new `P`.
  - In any other state, `cfg_we` is ignored.
- **ISSUE**: `m_drdy_i` = 1 for exactly this cycle. Clear the watchdog counter. Go to WAIT.
- **WAIT**: the counter increments each cycle.
  - `m_drdy_o` = 1: capture `m_out` into `rsp_out`, `rsp_err` ← 0, go to RESP.
  - Counter reaches `TIMEOUT` with `m_drdy_o` = 0: `rsp_out` ← 0, `rsp_err` ← 1, `timeout_err` ← 1, go to RESP.
  - `m_drdy_o` = 1 in the same cycle the counter reaches `TIMEOUT`: the product wins and no error is flagged.
- **RESP**
  - `rsp_valid[owner]` = 1 for one cycle, then go to IDLE.
  - If `rsp_err` is set, `m_rst` = 0 during this cycle.
- **Held outputs**: `m_p1`, `m_p2` and `m_P` stay stable from ISSUE through RESP.
- **Ignored inputs**: `m_drdy_o` outside WAIT, and `req_valid` outside IDLE.
- **err_clr**: clears `timeout_err`. A simultaneous set wins.
- **Counter**: width is ceil(log2(`TIMEOUT`+1)) bits and it never wraps.

## Timing
- **Reset** (`rst` = 0, asynchronous):
  - State IDLE, `ptr` = 0 (requester 0 highest priority), `P` = 0.
  - `m_p1`, `m_p2`, `rsp_out`, `rsp_err`, `timeout_err`, `m_drdy_i` and `rsp_valid` = 0.
  - `m_rst` = 0 while `rst` = 0, 1 otherwise.
  - Reset mid-operation abandons the transaction with no response.
- **Latency** for multiplier latency L, measured from `m_drdy_i` to `m_drdy_o`:
  - Grant in cycle t, `m_drdy_i` at t+1, `m_drdy_o` at t+1+L.
  - `rsp_valid` at t+2+L, next possible grant at t+3+L.
- **Throughput**: one operation per L+3 cycles.
- **Timeout response**: `rsp_valid` arrives `TIMEOUT`+3 cycles after the grant.
- **Registered outputs**: all outputs except `req_gnt` and `busy` are registered.

## Test plan
- **Single operation**: multiplier model with L = 5. `req_valid` = 0001, p1 = A, p2 = B. Expect:
  - `req_gnt` = 0001 at cycle 0 and `m_drdy_i` at cycle 1.
  - `rsp_valid` = 0001 at cycle 7, `rsp_out` = A·B mod P, `rsp_err` = 0.
- **Round robin**: `req_valid` = 1111 held, refilled after each grant. Grant order is 0, 1, 2, 3, 0. Each response goes to the correct owner and carries that owner's product.
- **Watchdog**: model never asserts `drdy_o`, `TIMEOUT` = 10. Expect:
  - `rsp_err` = 1, `rsp_out` = 0 and `timeout_err` = 1 at grant+13.
  - `m_rst` low for exactly one cycle.
  - `err_clr` clears `timeout_err`.
- **Timeout tie**: `drdy_o` arrives exactly on the `TIMEOUT` cycle. Expect a valid product and `timeout_err` = 0.
- **Configuration**:
  - `cfg_we` in WAIT is ignored and `m_P` is unchanged.
  - `cfg_we` together with a grant in IDLE issues with the new `P`.
- **Reset mid-WAIT**: apply `rst` = 0 during WAIT. Expect:
  - All outputs zero immediately and `m_rst` low.
  - No `rsp_valid` is produced.
  - After release, `ptr` = 0, so with `req_valid` = 1111 requester 0 is granted first.
